// File: rtl/psum_accum_bramctrl.sv
// psum_accum_bramctrl: PL-side controller for the psum BRAM.
// Read-modify-write accumulation of partial sums and zero-fill clear
// of words [0, i_clr_len). Single-port, so accesses are serialised.
// Ports: request i_vld/o_rdy/i_addr/i_psum/i_first, clear i_clr/i_clr_len/
// o_clr_done, status o_busy, BRAM bus mem_*. All outputs registered.
// Optional: `define PSUM_ACCUM_SAT_EN for a saturating adder and a sticky
// o_sat_flag output.
module psum_accum_bramctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_BYTE   = 4,
  parameter int unsigned IDX_WIDTH  = 16,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [IDX_WIDTH-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0] i_psum,
  input  logic                  i_first,
  input  logic                  i_clr,
  input  logic [IDX_WIDTH-1:0]  i_clr_len,
  output logic                  o_clr_done,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  output logic [NUM_BYTE-1:0]   mem_wren,
  output logic                  mem_enb,
  output logic                  mem_rst
`ifdef PSUM_ACCUM_SAT_EN
  ,
  output logic                  o_sat_flag
`endif
);

  typedef enum logic [2:0] {IDLE, RD, WT, WR, CLR, DONE} state_t;

  state_t                state, state_n;
  logic [IDX_WIDTH-1:0]  addr_q, addr_n, cnt_q, cnt_n, len_q, len_n;
  logic [DATA_WIDTH-1:0] psum_q, psum_n, sum;
  logic [1:0]            wt_q, wt_n;
  logic                  accept;

  logic                  rdy_d, busy_d, done_d, enb_d;
  logic [NUM_BYTE-1:0]   wren_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] idat_d;

  assign mem_rst = 1'b0;
  assign accept  = i_vld && o_rdy && !(state == IDLE && i_clr);

  function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic [IDX_WIDTH-1:0] idx);
    return ADDR_WIDTH'(idx) * ADDR_WIDTH'(NUM_BYTE);
  endfunction

`ifdef PSUM_ACCUM_SAT_EN
  logic signed [DATA_WIDTH:0] sum_wide;
  logic                       sum_sat, sat_d;

  always_comb begin
    sum_wide = $signed({mem_odat[DATA_WIDTH-1], mem_odat}) + $signed({psum_q[DATA_WIDTH-1], psum_q});
    sum_sat  = sum_wide[DATA_WIDTH] ^ sum_wide[DATA_WIDTH-1];
    if (sum_sat)
      sum = sum_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sum = sum_wide[DATA_WIDTH-1:0];
  end
`else
  always_comb sum = mem_odat + psum_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (i_clr)       state_n = (i_clr_len == '0) ? DONE : CLR;
        else if (accept) state_n = i_first ? WR : RD;
      end
      RD:   state_n = WT;
      WT:   if (wt_q == 2'(READ_LAT - 1)) state_n = WR;
      WR: begin
        if (accept) state_n = i_first ? WR : RD;
        else        state_n = IDLE;
      end
      CLR:  if (cnt_q == len_q - IDX_WIDTH'(1)) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state and
  // next latched data; the registered value then matches the current state.
  always_comb begin
    addr_n = addr_q;
    psum_n = psum_q;
    len_n  = len_q;
    cnt_n  = cnt_q;
    wt_n   = '0;
    if (accept) begin
      addr_n = i_addr;
      psum_n = i_psum;
    end
    if (state == IDLE && i_clr) begin
      len_n = i_clr_len;
      cnt_n = '0;
    end else if (state == CLR) begin
      cnt_n = cnt_q + IDX_WIDTH'(1);
    end
    if (state == WT) wt_n = wt_q + 2'd1;

    rdy_d  = (state_n == IDLE) || (state_n == WR);
    busy_d = (state_n != IDLE);
    done_d = (state_n == DONE);
    enb_d  = 1'b0;
    wren_d = '0;
    addr_d = mem_addr;
    idat_d = mem_idat;
    case (state_n)
      RD: begin
        enb_d  = 1'b1;
        addr_d = byte_addr(addr_n);
      end
      WR: begin
        enb_d  = 1'b1;
        wren_d = '1;
        addr_d = byte_addr(addr_n);
        idat_d = (state == WT) ? sum : psum_n;
      end
      CLR: begin
        enb_d  = 1'b1;
        wren_d = '1;
        addr_d = byte_addr(cnt_n);
        idat_d = '0;
      end
      default: ;
    endcase
`ifdef PSUM_ACCUM_SAT_EN
    sat_d = o_sat_flag || (state == WT && state_n == WR && sum_sat);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      psum_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wt_q       <= '0;
      o_rdy      <= 1'b0;
      o_busy     <= 1'b0;
      o_clr_done <= 1'b0;
      mem_enb    <= 1'b0;
      mem_wren   <= '0;
      mem_addr   <= '0;
      mem_idat   <= '0;
`ifdef PSUM_ACCUM_SAT_EN
      o_sat_flag <= 1'b0;
`endif
    end else begin
      addr_q     <= addr_n;
      psum_q     <= psum_n;
      len_q      <= len_n;
      cnt_q      <= cnt_n;
      wt_q       <= wt_n;
      o_rdy      <= rdy_d;
      o_busy     <= busy_d;
      o_clr_done <= done_d;
      mem_enb    <= enb_d;
      mem_wren   <= wren_d;
      mem_addr   <= addr_d;
      mem_idat   <= idat_d;
`ifdef PSUM_ACCUM_SAT_EN
      o_sat_flag <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_psum_accum_bramctrl.sv
module tb_psum_accum_bramctrl;
  localparam int RL    = 1;
  localparam int NEVER = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vld = 1'b0, i_first = 1'b0, i_clr = 1'b0;
  logic [15:0] i_addr = '0, i_clr_len = '0;
  logic [31:0] i_psum = '0;
  logic        o_rdy, o_clr_done, o_busy, mem_enb, mem_rst;
  logic [31:0] mem_addr, mem_idat, mem_odat;
  logic [3:0]  mem_wren;
`ifdef PSUM_ACCUM_SAT_EN
  logic        o_sat_flag;
`endif

  psum_accum_bramctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_BYTE(4), .IDX_WIDTH(16), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_addr(i_addr),
    .i_psum(i_psum), .i_first(i_first), .i_clr(i_clr), .i_clr_len(i_clr_len),
    .o_clr_done(o_clr_done), .o_busy(o_busy), .mem_addr(mem_addr),
    .mem_idat(mem_idat), .mem_odat(mem_odat), .mem_wren(mem_wren),
    .mem_enb(mem_enb), .mem_rst(mem_rst)
`ifdef PSUM_ACCUM_SAT_EN
    , .o_sat_flag(o_sat_flag)
`endif
  );

  always #5 clk = ~clk;

  // BRAM environment: 16 words, read-first, one-cycle read latency.
  logic [31:0] bram [16];
  always @(posedge clk) begin
    if (mem_enb) begin
      if (mem_wren == 4'hF) bram[mem_addr[5:2]] <= mem_idat;
      mem_odat <= bram[mem_addr[5:2]];
    end
  end

  // Reference model: logical memory contents plus a per-cycle bus schedule.
  int          cyc = 0, free_at = NEVER, sat_from = NEVER;
  bit          ev_wr [int];
  logic [31:0] ev_addr [int], ev_idat [int];
  bit          wr_acc [int], done_at [int];
  logic [31:0] ref_mem [16];
  logic [31:0] last_addr = '0, last_idat = '0;
  bit          undo_v = 0;
  int          undo_idx, undo_cyc;
  logic [31:0] undo_old;
  bit          acc_flag;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_addr, e_idat;
    logic [3:0]  e_wren;
    logic        e_enb, e_rdy, e_busy, e_done, e_sat;
    if (rst) begin
      {e_addr, e_idat, e_wren, e_enb, e_rdy, e_busy, e_done, e_sat} = '0;
    end else begin
      e_rdy  = (cyc >= free_at);
      e_busy = (cyc < free_at) || wr_acc.exists(cyc);
      e_done = done_at.exists(cyc);
      e_sat  = (cyc >= sat_from);
      if (ev_wr.exists(cyc)) begin
        e_enb  = 1'b1;
        e_wren = ev_wr[cyc] ? 4'hF : 4'h0;
        e_addr = ev_addr[cyc];
        e_idat = ev_wr[cyc] ? ev_idat[cyc] : last_idat;
      end else begin
        e_enb  = 1'b0;
        e_wren = 4'h0;
        e_addr = last_addr;
        e_idat = last_idat;
      end
      last_addr = e_addr;
      last_idat = e_idat;
    end
    chk("o_rdy", o_rdy, e_rdy);
    chk("o_busy", o_busy, e_busy);
    chk("o_clr_done", o_clr_done, e_done);
    chk("mem_enb", mem_enb, e_enb);
    chk("mem_wren", mem_wren, e_wren);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_idat", mem_idat, e_idat);
    chk("mem_rst", mem_rst, 0);
`ifdef PSUM_ACCUM_SAT_EN
    chk("o_sat_flag", o_sat_flag, e_sat);
`endif
  endtask

  task automatic model_apply(input bit vld, input bit first, input bit clr,
                             input logic [15:0] a, input logic [15:0] len, input logic [31:0] ps);
    bit rdy, idle, sat;
    longint s;
    logic [31:0] nv;
    acc_flag = 0;
    if (rst) return;
    rdy  = (cyc >= free_at);
    idle = rdy && !wr_acc.exists(cyc);
    if (idle && clr) begin
      for (int k = 0; k < int'(len); k++) begin
        ev_wr[cyc+1+k] = 1; ev_addr[cyc+1+k] = 32'(k * 4); ev_idat[cyc+1+k] = '0;
        ref_mem[k] = '0;
      end
      done_at[cyc+int'(len)+1] = 1;
      free_at = cyc + int'(len) + 2;
      undo_v = 0;
    end else if (vld && rdy) begin
      acc_flag = 1;
      undo_v = 1; undo_idx = int'(a[3:0]); undo_old = ref_mem[a[3:0]];
      if (first) begin
        nv = ps;
        undo_cyc = cyc + 1;
        free_at = cyc + 1;
      end else begin
        ev_wr[cyc+1] = 0; ev_addr[cyc+1] = 32'(a) * 4;
        s = longint'($signed(ref_mem[a[3:0]])) + longint'($signed(ps));
        sat = 0;
        nv = 32'(s);
`ifdef PSUM_ACCUM_SAT_EN
        if (s > 64'sd2147483647)       begin nv = 32'h7FFFFFFF; sat = 1; end
        else if (s < -64'sd2147483648) begin nv = 32'h80000000; sat = 1; end
`endif
        undo_cyc = cyc + 2 + RL;
        free_at = cyc + 2 + RL;
        if (sat && sat_from == NEVER) sat_from = undo_cyc;
      end
      ev_wr[undo_cyc] = 1; ev_addr[undo_cyc] = 32'(a) * 4; ev_idat[undo_cyc] = nv;
      wr_acc[undo_cyc] = 1;
      ref_mem[a[3:0]] = nv;
    end
  endtask

  task automatic step(input bit vld, input bit first, input bit clr,
                      input logic [15:0] a, input logic [15:0] len, input logic [31:0] ps);
    @(negedge clk);
    cyc++;
    check_outputs();
    i_vld = vld; i_first = first; i_clr = clr; i_addr = a; i_clr_len = len; i_psum = ps;
    model_apply(vld, first, clr, a, len, ps);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0);
  endtask

  task automatic issue(input bit first, input logic [15:0] a, input logic [31:0] ps);
    for (int n = 0; n < 20; n++) begin
      step(1, first, 0, a, '0, ps);
      if (acc_flag) break;
    end
    if (!acc_flag) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout cycle %0d: got not-accepted expected accepted", cyc);
    end
  endtask

  task automatic reset_on();
    @(negedge clk);
    cyc++;
    check_outputs();
    rst = 1'b1;
    {i_vld, i_first, i_clr} = '0;
    #1;
    chk("rst_now_enb", mem_enb, 0);
    chk("rst_now_wren", mem_wren, 0);
    chk("rst_now_rdy", o_rdy, 0);
    chk("rst_now_busy", o_busy, 0);
    if (undo_v && undo_cyc >= cyc) ref_mem[undo_idx] = undo_old;
    undo_v = 0;
    ev_wr.delete(); ev_addr.delete(); ev_idat.delete(); wr_acc.delete(); done_at.delete();
    free_at = NEVER; sat_from = NEVER; last_addr = '0; last_idat = '0;
  endtask

  task automatic reset_off();
    @(negedge clk);
    cyc++;
    check_outputs();
    rst = 1'b0;
    {i_vld, i_first, i_clr} = '0;
    free_at = cyc + 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    idle(3);
    reset_off();
    idle(1);
    // zero the whole model/BRAM; simultaneous i_vld must lose to the clear
    step(1, 0, 1, 16'd9, 16'd16, 32'h55);
    idle(18);

    // overwrite addr 5 with 0x10
    issue(1, 16'd5, 32'h10);
    idle(1);
    chk("ovw_addr", mem_addr, 32'h14);
    chk("ovw_idat", mem_idat, 32'h10);
    chk("ovw_wren", mem_wren, 32'hF);
    idle(1);

    // accumulate 0x22 into addr 5
    issue(0, 16'd5, 32'h22);
    idle(1);
    chk("acc_rd_rdy", o_rdy, 0); chk("acc_rd_enb", mem_enb, 1);
    chk("acc_rd_wren", mem_wren, 0); chk("acc_rd_addr", mem_addr, 32'h14);
    idle(1);
    chk("acc_wt_rdy", o_rdy, 0); chk("acc_wt_enb", mem_enb, 0);
    idle(1);
    chk("acc_wr_idat", mem_idat, 32'h32); chk("acc_wr_wren", mem_wren, 32'hF);
    chk("acc_wr_rdy", o_rdy, 1);
    idle(1);
    chk("acc_bram5", bram[5], 32'h32);

    // back-to-back accumulates into addr 3; each accepted during previous WR
    issue(1, 16'd3, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      issue(0, 16'd3, 32'(k));
      chk("b2b_accept_in_wr", mem_wren, 32'hF);
    end
    idle(5);
    chk("b2b_bram3", bram[3], 32'h6);

    // clear 4 words with i_vld also asserted
    step(1, 0, 1, 16'd9, 16'd4, 32'h77);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("clr_addr", mem_addr, 32'(k * 4));
      chk("clr_idat", mem_idat, 0);
      chk("clr_wren", mem_wren, 32'hF);
    end
    idle(1);
    chk("clr_done", o_clr_done, 1);
    idle(1);
    chk("clr_done_pulse", o_clr_done, 0);

    // zero-length clear
    step(0, 0, 1, '0, '0, '0);
    idle(1);
    chk("clr0_done", o_clr_done, 1);
    chk("clr0_enb", mem_enb, 0);
    idle(1);

    // overflow
    issue(1, 16'd7, 32'h7FFFFFFF);
    issue(0, 16'd7, 32'h1);
    idle(5);
`ifdef PSUM_ACCUM_SAT_EN
    chk("ovf_bram7", bram[7], 32'h7FFFFFFF);
    chk("ovf_sat_flag", o_sat_flag, 1);
`else
    chk("ovf_bram7", bram[7], 32'h80000000);
`endif

    // reset during WT drops the request
    issue(1, 16'd2, 32'h1234);
    issue(0, 16'd2, 32'h5);
    idle(1);
    reset_on();
    idle(2);
    reset_off();
    idle(1);
    chk("rst_rel_rdy", o_rdy, 1);
    idle(3);
    chk("rst_drop_bram2", bram[2], 32'h1234);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ps;
      ps = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
           16'($urandom_range(0, 15)), 16'($urandom_range(0, 6)), ps);
    end
    idle(10);
    for (int i = 0; i < 16; i++) chk("final_bram", bram[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
